// File: rtl/dmg_lcd_rx_pkg.sv
// Shared definitions for the DMG LCD receive path: panel geometry, FSM
// state encodings and the pin-timing constants of the reference generator.
package dmg_lcd_rx_pkg;

  localparam int DMG_H_PIXELS = 160;
  localparam int DMG_V_LINES  = 144;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    LINE  = 2'd2,
    GAP   = 2'd3
  } lcd_state_t;

  // Generator timing, in clk_8m cycles: hsync pulse width, position of the
  // clock pulse embedded in hsync, back porch after hsync, pixel clock
  // high/low time, and blanking lines after the last active line.
  localparam int GEN_HSYNC_CYC    = 4;
  localparam int GEN_HCLK_POS     = 1;
  localparam int GEN_BPORCH_CYC   = 2;
  localparam int GEN_PIX_HI_CYC   = 1;
  localparam int GEN_PIX_LO_CYC   = 1;
  localparam int GEN_VBLANK_LINES = 2;

  // Checkerboard shade produced by the generator for pixel (x, y).
  function automatic logic [1:0] checker_shade(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] xo;
    logic [7:0] yo;
    xo = x + 8'd88;
    yo = y + 8'd10;
    return {xo[4] ^ yo[4], xo[3] ^ yo[3]};
  endfunction

endpackage

// File: rtl/dmg_lcd_rx_edge.sv
// Input stage for one LCD pin: a sampling register plus a delayed copy,
// giving the registered level and single-cycle rise/fall indications.
module dmg_lcd_rx_edge (
  input  logic clk_8m,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic level_d;

  // Sample the pin and keep last cycle's sample for edge detection.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level   <= din;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/dmg_lcd_rx.sv
// DMG LCD receiver: recovers the 2-bit pixel stream with x/y coordinates,
// frame/line strobes, protocol error strobes and a lock indication.
module dmg_lcd_rx
  import dmg_lcd_rx_pkg::*;
#(
  parameter int H_PIXELS    = DMG_H_PIXELS,
  parameter int V_LINES     = DMG_V_LINES,
  parameter bit INVERT_DATA = 1'b1,
  parameter int TIMEOUT_CYC = 262143
) (
  input  logic       clk_8m,
  input  logic       rst,
  input  logic       lcd_d0,
  input  logic       lcd_d1,
  input  logic       lcd_hsync,
  input  logic       lcd_vsync,
  input  logic       lcd_clk,
  input  logic       lcd_altsig,
  output logic       pix_valid,
  output logic [1:0] pix_data,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       line_done,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_par,
  output logic       sync_err,
  output logic       locked
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic d0_lvl, d1_lvl, hsync_lvl, altsig_lvl;
  logic hsync_rise, hsync_fall, vsync_rise, clk_rise;
  logic d0_rise_unused, d0_fall_unused, d1_rise_unused, d1_fall_unused;
  logic vsync_lvl_unused, vsync_fall_unused, clk_lvl_unused, clk_fall_unused;
  logic alt_rise_unused, alt_fall_unused;

  dmg_lcd_rx_edge u_edge_d0 (.clk_8m(clk_8m), .rst(rst), .din(lcd_d0),
    .level(d0_lvl), .rise(d0_rise_unused), .fall(d0_fall_unused));
  dmg_lcd_rx_edge u_edge_d1 (.clk_8m(clk_8m), .rst(rst), .din(lcd_d1),
    .level(d1_lvl), .rise(d1_rise_unused), .fall(d1_fall_unused));
  dmg_lcd_rx_edge u_edge_hsync (.clk_8m(clk_8m), .rst(rst), .din(lcd_hsync),
    .level(hsync_lvl), .rise(hsync_rise), .fall(hsync_fall));
  dmg_lcd_rx_edge u_edge_vsync (.clk_8m(clk_8m), .rst(rst), .din(lcd_vsync),
    .level(vsync_lvl_unused), .rise(vsync_rise), .fall(vsync_fall_unused));
  dmg_lcd_rx_edge u_edge_clk (.clk_8m(clk_8m), .rst(rst), .din(lcd_clk),
    .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall_unused));
  dmg_lcd_rx_edge u_edge_alt (.clk_8m(clk_8m), .rst(rst), .din(lcd_altsig),
    .level(altsig_lvl), .rise(alt_rise_unused), .fall(alt_fall_unused));

  lcd_state_t    state_q, state_n;
  logic [7:0]    x_q, x_n, y_q, y_n;
  logic [TO_W-1:0] to_cnt;
  logic          timeout_hit;
  logic          pix_emit, line_end, frame_end, fs_n, err_n, lock_n, par_n;
  logic [1:0]    shade;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC));
  assign shade       = INVERT_DATA ? ~{d1_lvl, d0_lvl} : {d1_lvl, d0_lvl};

  // Next-state logic: vsync rise has top priority (new frame, error if one
  // was in progress), then timeout, then the per-state line/pixel handling.
  // Reaching frame_end implies no error since frame_start, since every error
  // and the timeout return to HUNT and only a vsync rise leaves it.
  always_comb begin
    state_n   = state_q;
    x_n       = x_q;
    y_n       = y_q;
    pix_emit  = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    fs_n      = 1'b0;
    err_n     = 1'b0;
    lock_n    = locked;
    par_n     = frame_par;
    if (vsync_rise) begin
      fs_n    = 1'b1;
      par_n   = altsig_lvl;
      state_n = ARMED;
      x_n     = 8'd0;
      y_n     = 8'd0;
      if (state_q != HUNT) begin
        err_n  = 1'b1;
        lock_n = 1'b0;
      end
    end else if (timeout_hit) begin
      state_n = HUNT;
      lock_n  = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (hsync_fall) begin
            state_n = LINE;
            x_n     = 8'd0;
          end
        end
        LINE: begin
          if (hsync_rise) begin
            err_n   = 1'b1;
            lock_n  = 1'b0;
            state_n = HUNT;
          end else if (clk_rise && !hsync_lvl) begin
            pix_emit = 1'b1;
            if (x_q == 8'(H_PIXELS - 1)) begin
              line_end = 1'b1;
              x_n      = 8'(H_PIXELS);
              if (y_q == 8'(V_LINES - 1)) begin
                frame_end = 1'b1;
                lock_n    = 1'b1;
                state_n   = HUNT;
              end else begin
                state_n = GAP;
              end
            end else begin
              x_n = x_q + 8'd1;
            end
          end
        end
        GAP: begin
          if (hsync_fall) begin
            state_n = LINE;
            x_n     = 8'd0;
            y_n     = y_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state_q     <= HUNT;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      pix_valid   <= 1'b0;
      pix_data    <= 2'd0;
      pix_x       <= 8'd0;
      pix_y       <= 8'd0;
      line_done   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_par   <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_q     <= state_n;
      x_q         <= x_n;
      y_q         <= y_n;
      pix_valid   <= pix_emit;
      if (pix_emit) begin
        pix_data <= shade;
        pix_x    <= x_q;
        pix_y    <= y_q;
      end
      line_done   <= line_end;
      frame_start <= fs_n;
      frame_done  <= frame_end;
      frame_par   <= par_n;
      sync_err    <= err_n;
      locked      <= lock_n;
    end
  end

  // Cycles since the last vsync rise, saturating at the timeout value.
  always_ff @(posedge clk_8m) begin
    if (rst || vsync_rise) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_dmg_lcd_rx.sv
// Self-checking bench for dmg_lcd_rx with a small built-in DMG-style
// generator and a pixel scoreboard.
module tb_dmg_lcd_rx;
  import dmg_lcd_rx_pkg::*;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int TO = 2000;

  logic       clk_8m = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_d0 = 1'b0, lcd_d1 = 1'b0, lcd_hsync = 1'b0;
  logic       lcd_vsync = 1'b0, lcd_clk = 1'b0, lcd_altsig = 1'b0;
  logic       pix_valid, line_done, frame_start, frame_done, frame_par, sync_err, locked;
  logic [1:0] pix_data;
  logic [7:0] pix_x, pix_y;

  dmg_lcd_rx #(.H_PIXELS(H), .V_LINES(V), .INVERT_DATA(1'b0), .TIMEOUT_CYC(TO)) dut (
    .clk_8m(clk_8m), .rst(rst), .lcd_d0(lcd_d0), .lcd_d1(lcd_d1),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_clk(lcd_clk),
    .lcd_altsig(lcd_altsig), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .line_done(line_done),
    .frame_start(frame_start), .frame_done(frame_done), .frame_par(frame_par),
    .sync_err(sync_err), .locked(locked)
  );

  always #5 clk_8m = ~clk_8m;

  typedef struct packed {
    logic [1:0] data;
    logic [7:0] x;
    logic [7:0] y;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   n_checks = 0, n_pass = 0;
  int   pv_cnt = 0, ld_cnt = 0, fd_cnt = 0, fs_cnt = 0, err_cnt = 0;
  logic exp_par = 1'b0, exp_fs_err = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_8m);
    #1;
  endtask

  // One line: hsync pulse (with embedded clock pulse), back porch, npix pixels.
  task automatic applyStimulus(input int y, input int npix, input bit vs, input bit want);
    pix_t e;
    lcd_hsync = 1'b1;
    lcd_vsync = vs;
    for (int c = 0; c < GEN_HSYNC_CYC; c++) begin
      lcd_clk = (c == GEN_HCLK_POS);
      tick(1);
    end
    lcd_hsync = 1'b0;
    lcd_vsync = 1'b0;
    lcd_clk   = 1'b0;
    tick(GEN_BPORCH_CYC);
    for (int p = 0; p < npix; p++) begin
      {lcd_d1, lcd_d0} = checker_shade(8'(p), 8'(y));
      lcd_clk = 1'b1;
      if (want) begin
        e.data = checker_shade(8'(p), 8'(y));
        e.x    = 8'(p);
        e.y    = 8'(y);
        exp_q.push_back(e);
      end
      tick(GEN_PIX_HI_CYC);
      lcd_clk = 1'b0;
      tick(GEN_PIX_LO_CYC);
    end
  endtask

  task automatic sendFrame(input bit want, input bit par);
    lcd_altsig = par;
    exp_par    = par;
    for (int l = 0; l < V; l++) applyStimulus(l, H, (l == 0), want);
    for (int b = 0; b < GEN_VBLANK_LINES; b++) applyStimulus(V + b, H, 1'b0, 1'b0);
  endtask

  // Scoreboard and strobe monitor, sampled away from the active edge.
  always @(negedge clk_8m) begin
    if (pix_valid) begin
      pv_cnt++;
      checkOutput("pix_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("pix_data", pix_data, mon_e.data);
        checkOutput("pix_x", pix_x, mon_e.x);
        checkOutput("pix_y", pix_y, mon_e.y);
        checkOutput("line_done", line_done, mon_e.x == 8'(H - 1));
        checkOutput("frame_done", frame_done, (mon_e.x == 8'(H - 1)) && (mon_e.y == 8'(V - 1)));
      end
    end else begin
      checkOutput("stray_strobe", {line_done, frame_done}, 0);
    end
    if (line_done) ld_cnt++;
    if (frame_done) fd_cnt++;
    if (sync_err) err_cnt++;
    if (frame_start) begin
      fs_cnt++;
      checkOutput("frame_par", frame_par, exp_par);
      checkOutput("fs_sync_err", sync_err, exp_fs_err);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pv0, ld0, fd0, fs0, err0, waited;
    tick(3);
    checkOutput("reset_outputs", {pix_valid, pix_data, pix_x, pix_y, line_done, frame_start,
                                  frame_done, frame_par, sync_err, locked}, 0);
    rst = 1'b0;
    tick(2);
    checkOutput("idle_outputs", {pix_valid, line_done, frame_start, frame_done, sync_err, locked}, 0);

    $display("[TB] clean loopback frames");
    for (int f = 0; f < 3; f++) begin
      pv0 = pv_cnt; ld0 = ld_cnt; fd0 = fd_cnt; fs0 = fs_cnt;
      sendFrame(1'b1, f[0]);
      checkOutput("frame_pixels", pv_cnt - pv0, H * V);
      checkOutput("frame_lines", ld_cnt - ld0, V);
      checkOutput("frame_done_cnt", fd_cnt - fd0, 1);
      checkOutput("frame_start_cnt", fs_cnt - fs0, 1);
      checkOutput("locked_after_frame", locked, 1);
    end
    checkOutput("clean_sync_err", err_cnt, 0);

    $display("[TB] short line");
    err0 = err_cnt; ld0 = ld_cnt; fd0 = fd_cnt;
    lcd_altsig = 1'b1;
    exp_par    = 1'b1;
    applyStimulus(0, H, 1'b1, 1'b1);
    applyStimulus(1, H, 1'b0, 1'b1);
    applyStimulus(2, 10, 1'b0, 1'b1);
    for (int l = 3; l < V + GEN_VBLANK_LINES; l++) applyStimulus(l, H, 1'b0, 1'b0);
    checkOutput("short_line_err", err_cnt - err0, 1);
    checkOutput("short_line_unlocked", locked, 0);
    checkOutput("short_line_ld", ld_cnt - ld0, 2);
    checkOutput("short_line_fd", fd_cnt - fd0, 0);
    sendFrame(1'b1, 1'b0);
    checkOutput("relock_after_short", locked, 1);

    $display("[TB] vsync mid-frame");
    err0 = err_cnt; fs0 = fs_cnt; fd0 = fd_cnt;
    lcd_altsig = 1'b1;
    exp_par    = 1'b1;
    for (int l = 0; l < 3; l++) applyStimulus(l, H, (l == 0), 1'b1);
    exp_fs_err = 1'b1;
    applyStimulus(0, H, 1'b1, 1'b1);
    exp_fs_err = 1'b0;
    for (int l = 1; l < V + GEN_VBLANK_LINES; l++) applyStimulus(l, H, 1'b0, (l < V));
    checkOutput("short_frame_err", err_cnt - err0, 1);
    checkOutput("short_frame_fs", fs_cnt - fs0, 2);
    checkOutput("short_frame_fd", fd_cnt - fd0, 1);
    checkOutput("short_frame_locked", locked, 1);

    $display("[TB] input timeout");
    err0 = err_cnt;
    tick(TO - 400);
    checkOutput("locked_before_timeout", locked, 1);
    waited = 0;
    while (locked && waited < 600) begin
      tick(1);
      waited++;
    end
    checkOutput("timeout_unlock", locked, 0);
    checkOutput("timeout_no_err", err_cnt - err0, 0);
    pv0 = pv_cnt;
    sendFrame(1'b1, 1'b0);
    checkOutput("relock_after_timeout", locked, 1);
    checkOutput("timeout_frame_pixels", pv_cnt - pv0, H * V);

    $display("[TB] reset mid-frame");
    lcd_altsig = 1'b1;
    exp_par    = 1'b1;
    for (int l = 0; l < 3; l++) applyStimulus(l, H, (l == 0), 1'b1);
    applyStimulus(3, 8, 1'b0, 1'b1);
    {lcd_d1, lcd_d0} = checker_shade(8'd8, 8'd3);
    lcd_clk = 1'b1;
    rst     = 1'b1;
    tick(1);
    checkOutput("reset_midframe", {pix_valid, pix_data, pix_x, pix_y, line_done, frame_start,
                                   frame_done, frame_par, sync_err, locked}, 0);
    rst     = 1'b0;
    lcd_clk = 1'b0;
    tick(1);
    pv0 = pv_cnt;
    for (int l = 4; l < V + GEN_VBLANK_LINES; l++) applyStimulus(l, H, 1'b0, 1'b0);
    checkOutput("no_pix_after_reset", pv_cnt - pv0, 0);
    pv0 = pv_cnt;
    sendFrame(1'b1, 1'b0);
    checkOutput("pixels_after_reset", pv_cnt - pv0, H * V);
    checkOutput("locked_after_reset", locked, 1);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
